// File: rtl/prio_encoder_8x3_seq.sv
// prio_encoder_8x3_seq: registered priority encoder, serialises pending requests highest index first (ENC_OVR_EN adds ovr_err_o)
module prio_encoder_8x3_seq #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in_i,
    input  logic         req_valid_i,
    output logic [W-1:0] code_o,
    output logic         code_valid_o,
    input  logic         code_ready_i,
    output logic [N-1:0] pending_o
`ifdef ENC_OVR_EN
    ,
    output logic         ovr_err_o
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0]   state_q, state_d;
    logic [W-1:0] code_q, code_d, hi;
    logic [N-1:0] pending_q, nxt, clr, new_req;
    logic         hs;
    assign code_o       = code_q;
    assign code_valid_o = state_q == HOLD;
    assign pending_o    = pending_q;
    // Merge requests into the pending set and pick the next code once the output is free
    always_comb begin
        hs      = code_valid_o & code_ready_i;
        clr     = hs ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;
        new_req = req_valid_i ? req_in_i : '0;
        nxt     = (pending_q & ~clr) | new_req;
        hi      = '0;
        for (int i = 0; i < N; i++)
            if (nxt[i]) hi = i[W-1:0];
        state_d = (state_q == IDLE || hs) ? ((nxt != '0) ? HOLD : IDLE) : state_q;
        code_d  = ((state_q == IDLE || hs) && nxt != '0) ? hi : code_q;
    end
    // State, presented code and pending set
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= nxt;
        end
    end
`ifdef ENC_OVR_EN
    // Pulse when a request lands on a bit that is pending and not being served this edge
    always_ff @(posedge clk) begin
        if (rst) ovr_err_o <= 1'b0;
        else     ovr_err_o <= |(new_req & pending_q & ~clr);
    end
`endif
endmodule

// File: tb/tb_prio_encoder_8x3_seq.sv
// tb_prio_encoder_8x3_seq: directed self-checking bench for prio_encoder_8x3_seq
module tb_prio_encoder_8x3_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_in_i = '0;
    logic       req_valid_i = 1'b0;
    logic       code_ready_i = 1'b0;
    logic [2:0] code_o;
    logic       code_valid_o;
    logic [7:0] pending_o;
    int         n_cmp = 0;
    int         n_bad = 0;
`ifdef ENC_OVR_EN
    logic       ovr_err_o;
`endif

    prio_encoder_8x3_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_in_i     (req_in_i),
        .req_valid_i  (req_valid_i),
        .code_o       (code_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .pending_o    (pending_o)
`ifdef ENC_OVR_EN
        ,
        .ovr_err_o    (ovr_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [2:0] c, input logic [7:0] p);
        check({tag, ".valid"}, {31'd0, code_valid_o}, {31'd0, v});
        if (v) check({tag, ".code"}, {29'd0, code_o}, {29'd0, c});
        check({tag, ".pend"}, {24'd0, pending_o}, {24'd0, p});
    endtask

    task automatic drive(input logic rv, input logic [7:0] r, input logic rdy);
        req_valid_i  = rv;
        req_in_i     = r;
        code_ready_i = rdy;
    endtask

    initial begin
        tick();
        tick();
        expect_out("rst0", 1'b0, 3'd0, 8'h00);
        check("rst0.code", {29'd0, code_o}, 32'd0);
        rst = 1'b0;
        // reset in the middle of a full drain
        drive(1'b1, 8'hFF, 1'b1);
        tick();
        expect_out("t1a", 1'b1, 3'd7, 8'hFF);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t1b", 1'b1, 3'd6, 8'h7F);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_out("t1rst", 1'b0, 3'd0, 8'h00);
        check("t1rst.code", {29'd0, code_o}, 32'd0);
        // empty request and ready while idle do nothing
        drive(1'b1, 8'h00, 1'b1);
        tick();
        expect_out("zero", 1'b0, 3'd0, 8'h00);
        // single request
        drive(1'b1, 8'h04, 1'b1);
        tick();
        expect_out("t2a", 1'b1, 3'd2, 8'h04);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t2b", 1'b0, 3'd0, 8'h00);
        // multi-hot drained highest first, back to back
        drive(1'b1, 8'hA5, 1'b1);
        tick();
        expect_out("t3a", 1'b1, 3'd7, 8'hA5);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t3b", 1'b1, 3'd5, 8'h25);
        tick();
        expect_out("t3c", 1'b1, 3'd2, 8'h05);
        tick();
        expect_out("t3d", 1'b1, 3'd0, 8'h01);
        tick();
        expect_out("t3e", 1'b0, 3'd0, 8'h00);
        // no preemption while stalled
        drive(1'b1, 8'h08, 1'b0);
        tick();
        expect_out("t4a", 1'b1, 3'd3, 8'h08);
        drive(1'b1, 8'h80, 1'b0);
        tick();
        expect_out("t4b", 1'b1, 3'd3, 8'h88);
        drive(1'b0, 8'h00, 1'b0);
        tick();
        expect_out("t4c", 1'b1, 3'd3, 8'h88);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t4d", 1'b1, 3'd7, 8'h80);
        tick();
        expect_out("t4e", 1'b0, 3'd0, 8'h00);
        // handshake and re-request of the same bit
        drive(1'b1, 8'h10, 1'b0);
        tick();
        expect_out("t5a", 1'b1, 3'd4, 8'h10);
        drive(1'b1, 8'h10, 1'b1);
        tick();
        expect_out("t5b", 1'b1, 3'd4, 8'h10);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t5c", 1'b0, 3'd0, 8'h00);
        // merge of an already-pending bit
        drive(1'b1, 8'h02, 1'b0);
        tick();
        expect_out("t6a", 1'b1, 3'd1, 8'h02);
`ifdef ENC_OVR_EN
        check("t6a.ovr", {31'd0, ovr_err_o}, 32'd0);
`endif
        drive(1'b1, 8'h02, 1'b0);
        tick();
        expect_out("t6b", 1'b1, 3'd1, 8'h02);
`ifdef ENC_OVR_EN
        check("t6b.ovr", {31'd0, ovr_err_o}, 32'd1);
`endif
        drive(1'b0, 8'h00, 1'b0);
        tick();
        expect_out("t6c", 1'b1, 3'd1, 8'h02);
`ifdef ENC_OVR_EN
        check("t6c.ovr", {31'd0, ovr_err_o}, 32'd0);
`endif
        drive(1'b0, 8'h00, 1'b1);
        tick();
        expect_out("t6d", 1'b0, 3'd0, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
